// File: rtl/io_bus_bridge_if.sv
// Generic 8-bit I/O bus (20-bit address). It is used twice: once for the CPU-facing port
// and once for the slave-tree port. The master drives the request side; the slave drives the response side.
interface io_bus_bridge_if;
  logic [19:0] address;
  logic        read;
  logic        write;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        irq;

  modport master (output address, read, write, wdata, input ack, rdata, irq);
  modport slave  (input address, read, write, wdata, output ack, rdata, irq);
endinterface

// File: rtl/io_bus_bridge.sv
// Registered CPU-to-slave-tree I/O bridge: strobe/ack conversion, optional access timeout
// (enabled by IO_BRIDGE_TIMEOUT_EN), and a two-flop interrupt synchroniser.
module io_bus_bridge #(
    parameter int unsigned g_timeout = 255
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    io_bus_bridge_if.slave        up,
    io_bus_bridge_if.master       dn,
    output logic                  timeout_flag,
    output logic [19:0]           timeout_addr,
    input  logic                  timeout_clear
);

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

    state_t      state_q;
    logic        is_rd_q;
    logic        ack_q, rd_q, wr_q;
    logic [7:0]  rdata_q, wdata_q;
    logic [19:0] addr_q;
    logic        irq_meta_q, irq_sync_q;
    logic        expire;

`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(g_timeout);
    localparam logic [CW-1:0] CNT_MAX = CW'(g_timeout - 1);

    logic [CW-1:0] cnt_q;
    logic          to_flag_q;
    logic [19:0]   to_addr_q;

    assign expire = (cnt_q == CNT_MAX);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q     <= '0;
            to_flag_q <= 1'b0;
            to_addr_q <= '0;
        end else begin
            if (state_q == IDLE && (up.read || up.write))
                cnt_q <= '0;
            else if (state_q == BUSY && !dn.ack && !expire)
                cnt_q <= cnt_q + CW'(1);

            // A late ack in the expiry cycle still counts as a normal completion.
            if (state_q == BUSY && !dn.ack && expire) begin
                to_flag_q <= 1'b1;
                if (!to_flag_q || timeout_clear)
                    to_addr_q <= addr_q;
            end else if (timeout_clear) begin
                to_flag_q <= 1'b0;
            end
        end
    end

    assign timeout_flag = to_flag_q;
    assign timeout_addr = to_addr_q;
`else
    logic unused_cfg;

    assign expire       = 1'b0;
    assign timeout_flag = 1'b0;
    assign timeout_addr = '0;
    assign unused_cfg   = &{1'b0, timeout_clear, (g_timeout != 0)};
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            is_rd_q <= 1'b0;
            ack_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 8'h00;
            wdata_q <= 8'h00;
            addr_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Write has priority when both requests are raised together.
                    if (up.write || up.read) begin
                        addr_q  <= up.address;
                        wdata_q <= up.wdata;
                        wr_q    <= up.write;
                        rd_q    <= !up.write;
                        is_rd_q <= !up.write;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (dn.ack) begin
                        if (is_rd_q) rdata_q <= dn.rdata;
                        ack_q   <= 1'b1;
                        state_q <= RECOVER;
                    end else if (expire) begin
                        if (is_rd_q) rdata_q <= 8'hFF;
                        ack_q   <= 1'b1;
                        state_q <= RECOVER;
                    end
                end
                RECOVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_meta_q <= 1'b0;
            irq_sync_q <= 1'b0;
        end else begin
            irq_meta_q <= dn.irq;
            irq_sync_q <= irq_meta_q;
        end
    end

    assign up.ack     = ack_q;
    assign up.rdata   = rdata_q;
    assign up.irq     = irq_sync_q;
    assign dn.address = addr_q;
    assign dn.read    = rd_q;
    assign dn.write   = wr_q;
    assign dn.wdata   = wdata_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge: a vector table of normal accesses, plus hand-written
// sequences for timeout, reset, late-ack and interrupt corners.
module tb_io_bus_bridge;
  localparam int TO = 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        timeout_flag, timeout_clear;
  logic [19:0] timeout_addr;
  int          checks = 0, errors = 0;
  int          rd_cnt = 0, wr_cnt = 0, ack_cnt = 0;

  io_bus_bridge_if up_if();
  io_bus_bridge_if dn_if();

  io_bus_bridge #(.g_timeout(TO)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .up(up_if), .dn(dn_if),
    .timeout_flag(timeout_flag), .timeout_addr(timeout_addr), .timeout_clear(timeout_clear)
  );

  always #5 clk_clk = ~clk_clk;

  always @(negedge clk_clk) if (reset_reset_n) begin
    rd_cnt  <= rd_cnt + int'(dn_if.read);
    wr_cnt  <= wr_cnt + int'(dn_if.write);
    ack_cnt <= ack_cnt + int'(up_if.ack);
  end

  typedef struct {
    bit          wr;
    bit          both;
    logic [19:0] addr;
    logic [7:0]  wdata;
    int          dly;
    logic [7:0]  srd;
    logic [7:0]  exp;
  } vec_t;

  task automatic tick;
    @(posedge clk_clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v);
    int rd0, wr0, ak0;
    rd0 = rd_cnt; wr0 = wr_cnt; ak0 = ack_cnt;
    up_if.address = v.addr; up_if.wdata = v.wdata;
    up_if.write = v.wr; up_if.read = v.both ? 1'b1 : !v.wr;
    tick;
    check("strobe_wr", dn_if.write, v.wr);
    check("strobe_rd", dn_if.read, !v.wr);
    check("dn_address", dn_if.address, v.addr);
    if (v.wr) check("dn_wdata", dn_if.wdata, v.wdata);
    for (int d = 0; d < v.dly; d++) begin
      check("ack_early", up_if.ack, 0);
      tick;
    end
    dn_if.ack = 1'b1; dn_if.rdata = v.srd;
    tick;
    dn_if.ack = 1'b0; dn_if.rdata = 8'hEE;
    check("up_ack", up_if.ack, 1);
    check("up_rdata", up_if.rdata, v.exp);
    tick;
    up_if.read = 1'b0; up_if.write = 1'b0;
    check("ack_pulse", up_if.ack, 0);
    tick; tick;
    check("n_dn_read", rd_cnt - rd0, int'(!v.wr));
    check("n_dn_write", wr_cnt - wr0, int'(v.wr));
    check("n_up_ack", ack_cnt - ak0, 1);
  endtask

`ifdef IO_BRIDGE_TIMEOUT_EN
  task automatic to_access(input logic [19:0] a, input bit clr, input bit ak,
                           input logic [7:0] exp_rd, input bit exp_flag, input logic [19:0] exp_ta);
    up_if.address = a; up_if.read = 1'b1;
    tick;
    for (int c = 1; c < TO; c++) begin
      check("to_ack_early", up_if.ack, 0);
      tick;
    end
    check("to_ack_early", up_if.ack, 0);
    timeout_clear = clr; dn_if.ack = ak; dn_if.rdata = 8'h11;
    tick;
    timeout_clear = 1'b0; dn_if.ack = 1'b0; dn_if.rdata = 8'hEE;
    check("to_up_ack", up_if.ack, 1);
    check("to_rdata", up_if.rdata, exp_rd);
    check("to_flag", timeout_flag, exp_flag);
    check("to_addr", timeout_addr, exp_ta);
    tick;
    up_if.read = 1'b0;
    tick; tick;
  endtask
`endif

  vec_t vecs[5];
  int   ak0, rd0, wr0;
  bit   seen;

  initial begin
    vecs[0] = '{wr:0, both:0, addr:20'h12345, wdata:8'h00, dly:3, srd:8'hA5, exp:8'hA5};
    vecs[1] = '{wr:1, both:0, addr:20'h00010, wdata:8'h3C, dly:0, srd:8'h77, exp:8'hA5};
    vecs[2] = '{wr:0, both:0, addr:20'hFFFFF, wdata:8'h00, dly:0, srd:8'h5A, exp:8'h5A};
    vecs[3] = '{wr:1, both:1, addr:20'h00ABC, wdata:8'hC3, dly:1, srd:8'h99, exp:8'h5A};
    vecs[4] = '{wr:0, both:0, addr:20'h00000, wdata:8'h00, dly:5, srd:8'h00, exp:8'h00};

    up_if.address = '0; up_if.read = 0; up_if.write = 0; up_if.wdata = '0;
    dn_if.ack = 0; dn_if.rdata = 8'hEE; dn_if.irq = 0; timeout_clear = 0;
    tick; tick;
    check("rst_up_ack", up_if.ack, 0);
    check("rst_dn_read", dn_if.read, 0);
    check("rst_dn_write", dn_if.write, 0);
    check("rst_up_rdata", up_if.rdata, 0);
    check("rst_dn_address", dn_if.address, 0);
    check("rst_dn_wdata", dn_if.wdata, 0);
    check("rst_up_irq", up_if.irq, 0);
    check("rst_to_flag", timeout_flag, 0);
    check("rst_to_addr", timeout_addr, 0);
    reset_reset_n = 1'b1;
    tick;

    foreach (vecs[i]) do_access(vecs[i]);

    // Stray ack while idle must not disturb read data.
    ak0 = ack_cnt;
    dn_if.ack = 1'b1; dn_if.rdata = 8'h66;
    tick;
    dn_if.ack = 1'b0; dn_if.rdata = 8'hEE;
    tick;
    check("idle_ack_ignored", ack_cnt - ak0, 0);
    check("idle_rdata_kept", up_if.rdata, 8'h00);

`ifdef IO_BRIDGE_TIMEOUT_EN
    to_access(20'h54321, 0, 0, 8'hFF, 1, 20'h54321);
    ak0 = ack_cnt;
    dn_if.ack = 1'b1; dn_if.rdata = 8'h33;
    tick;
    dn_if.ack = 1'b0; dn_if.rdata = 8'hEE;
    tick;
    check("late_ack_ignored", ack_cnt - ak0, 0);
    check("late_ack_rdata", up_if.rdata, 8'hFF);
    to_access(20'h00002, 0, 0, 8'hFF, 1, 20'h54321);
    to_access(20'h0ABCD, 1, 0, 8'hFF, 1, 20'h0ABCD);
    timeout_clear = 1'b1;
    tick;
    timeout_clear = 1'b0;
    check("clear_flag", timeout_flag, 0);
    check("clear_addr_kept", timeout_addr, 20'h0ABCD);
    to_access(20'h00111, 0, 1, 8'h11, 0, 20'h0ABCD);
`else
    ak0 = ack_cnt;
    up_if.address = 20'h54321; up_if.read = 1'b1;
    for (int c = 0; c < 20; c++) begin
      timeout_clear = (c == 10);
      tick;
    end
    timeout_clear = 1'b0;
    check("no_timeout_ack", ack_cnt - ak0, 0);
    check("no_timeout_flag", timeout_flag, 0);
    check("no_timeout_addr", timeout_addr, 0);
    dn_if.ack = 1'b1; dn_if.rdata = 8'h11;
    tick;
    dn_if.ack = 1'b0; dn_if.rdata = 8'hEE;
    check("slow_up_ack", up_if.ack, 1);
    check("slow_rdata", up_if.rdata, 8'h11);
    tick;
    up_if.read = 1'b0;
    tick; tick;
`endif

    // Reset in the middle of an access.
    up_if.address = 20'h22222; up_if.read = 1'b1;
    tick; tick;
    reset_reset_n = 1'b0;
    #1;
    check("mid_rst_up_ack", up_if.ack, 0);
    check("mid_rst_dn_read", dn_if.read, 0);
    check("mid_rst_dn_address", dn_if.address, 0);
    check("mid_rst_rdata", up_if.rdata, 0);
    check("mid_rst_flag", timeout_flag, 0);
    up_if.read = 1'b0;
    tick; tick;
    reset_reset_n = 1'b1;
    ak0 = ack_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    dn_if.ack = 1'b1;
    tick;
    dn_if.ack = 1'b0;
    for (int c = 0; c < 12; c++) tick;
    check("post_rst_no_ack", ack_cnt - ak0, 0);
    check("post_rst_no_strobe", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
    do_access('{wr:0, both:0, addr:20'h22222, wdata:8'h00, dly:2, srd:8'hC7, exp:8'hC7});

    // Interrupt synchroniser, driven off the clock edge.
    for (int lvl = 1; lvl >= 0; lvl--) begin
      #3 dn_if.irq = lvl[0];
      tick;
      check("irq_min_latency", up_if.irq, !lvl[0]);
      seen = 0;
      for (int c = 0; c < 2 && !seen; c++) begin
        tick;
        seen = (up_if.irq == lvl[0]);
      end
      check("irq_follow", up_if.irq, lvl[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
